// File: rtl/shifter_3stage_seq.sv
// Three-stage sequential barrel shifter driven by a base-3 shift code.
// One code digit is applied per state; SLL, SRA and ROR modes.
module shifter_3stage_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [5:0]  shift_code,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    S0,
    S1,
    S2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] work_q;
  logic [5:0]  code_q;
  logic [1:0]  mode_q;
  logic [1:0]  digit;
  logic [3:0]  wt;
  logic [3:0]  amt;
  logic        bad_dig;
  logic        bad_mode;
  logic [15:0] shifted;

  function automatic logic [15:0] shift_fn(
    input logic [15:0] v,
    input logic [3:0]  n,
    input logic [1:0]  m
  );
    logic [31:0] rot;
    logic [15:0] res;
    rot = {v, v} >> n;
    unique case (m)
      2'b00:   res = v << n;
      2'b01:   res = $signed(v) >>> n;
      2'b10:   res = rot[15:0];
      default: res = v;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    digit   = 2'b00;
    wt      = 4'd0;
    unique case (state_q)
      IDLE: if (start) state_d = S0;
      S0: begin
        digit   = code_q[1:0];
        wt      = 4'd1;
        state_d = S1;
      end
      S1: begin
        digit   = code_q[3:2];
        wt      = 4'd3;
        state_d = S2;
      end
      S2: begin
        digit   = code_q[5:4];
        wt      = 4'd9;
        state_d = IDLE;
      end
    endcase
    // digit2 can only weigh 0 or 9, so 2'b10 is illegal there
    bad_dig  = (digit == 2'b11) ||
               ((state_q == S2) && (digit == 2'b10));
    bad_mode = (mode_q == 2'b11);
    amt      = 4'd0;
    if (!bad_dig && !bad_mode) begin
      unique case (1'b1)
        (digit == 2'b01): amt = wt;
        (digit == 2'b10): amt = {wt[2:0], 1'b0};
        default:          amt = 4'd0;
      endcase
    end
    shifted = shift_fn(work_q, amt, mode_q);
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      code_q   <= '0;
      mode_q   <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= data_in;
            code_q <= shift_code;
            mode_q <= mode;
            err    <= 1'b0;
          end
        end
        S0: begin
          work_q <= shifted;
          if (bad_dig || bad_mode) err <= 1'b1;
        end
        S1: begin
          work_q <= shifted;
          if (bad_dig) err <= 1'b1;
        end
        S2: begin
          work_q   <= shifted;
          data_out <= shifted;
          done     <= 1'b1;
          if (bad_dig) err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_3stage_seq.sv
// Self-checking bench for shifter_3stage_seq.
// Reference model sums legal digit weights and shifts once.
module tb_shifter_3stage_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic [5:0]  shift_code;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  shifter_3stage_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .shift_code(shift_code),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [15:0] d,
    input  logic [5:0]  c,
    input  logic [1:0]  m,
    output logic [15:0] r,
    output logic        e
  );
    int tot;
    int dg;
    int w;
    e   = (m == 2'b11);
    tot = 0;
    for (int s = 0; s < 3; s++) begin
      dg = (int'(c) >> (2 * s)) & 3;
      w  = (s == 0) ? 1 : (s == 1) ? 3 : 9;
      if (dg == 3 || (s == 2 && dg == 2)) e = 1'b1;
      else tot += dg * w;
    end
    r = d;
    if (m != 2'b11) begin
      for (int i = 0; i < 16; i++) begin
        case (m)
          2'b00:   r[i] = (i >= tot) ? d[i - tot] : 1'b0;
          2'b01:   r[i] = (i + tot > 15) ? d[15] : d[i + tot];
          default: r[i] = d[(i + tot) % 16];
        endcase
      end
    end
  endfunction

  task automatic run_op(
    input  logic [15:0] d,
    input  logic [5:0]  c,
    input  logic [1:0]  m,
    output logic [15:0] r,
    output logic        e,
    output int          lat,
    output logic        e_acc
  );
    @(negedge clk);
    start      = 1'b1;
    data_in    = d;
    shift_code = c;
    mode       = m;
    @(posedge clk);
    #1;
    e_acc      = err;
    start      = 1'b0;
    data_in    = 16'($urandom);
    shift_code = 6'($urandom);
    mode       = 2'($urandom);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = data_out;
    e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;
    shift_code = '0;
    mode = '0;
    #3;
    checks++;
    if ({busy, done, err, data_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got b%0b d%0b e%0b out=%h want 0",
               busy, done, err, data_out);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] d [5] = '{16'h0001, 16'h8000, 16'h1234,
                           16'hABCD, 16'h5555};
    logic [5:0]  c [5] = '{6'b011000, 6'b000110, 6'b000101,
                           6'b000011, 6'b101111};
    logic [1:0]  m [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [15:0] want [5] = '{16'h8000, 16'hFC00, 16'h4123,
                              16'hABCD, 16'h5555};
    logic        werr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] r;
    logic        e;
    logic        ea;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(d[i], c[i], m[i], r, e, lat, ea);
      checks++;
      if (r !== want[i] || e !== werr[i] || lat != 3) begin
        errors++;
        $display("FAIL directed%0d got %h err%0b lat%0d want %h err%0b lat3",
                 i, r, e, lat, want[i], werr[i]);
      end
      checks++;
      if (ea !== 1'b0) begin
        errors++;
        $display("FAIL err_clear%0d got %0b want 0", i, ea);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [15:0] held;
    logic        eh;
    held = data_out;
    eh   = err;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || data_out !== held || err !== eh || busy) begin
        errors++;
        $display("FAIL idle_hold got d%0b out=%h e%0b want 0 %h %0b",
                 done, data_out, err, held, eh);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [5:0]  c;
    logic [1:0]  m;
    logic [15:0] r;
    logic [15:0] want;
    logic        e;
    logic        werr;
    logic        ea;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      c = 6'($urandom);
      m = 2'($urandom);
      model(d, c, m, want, werr);
      run_op(d, c, m, r, e, lat, ea);
      checks++;
      if (r !== want || e !== werr || lat != 3 || ea !== 1'b0) begin
        errors++;
        $display("FAIL rand d=%h c=%b m=%0d got %h e%0b l%0d want %h e%0b",
                 d, c, m, r, e, lat, want, werr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa;
    logic [15:0] wb;
    logic        ea;
    logic        eb;
    logic [15:0] da;
    logic [15:0] db;
    int          pulses;
    da = 16'($urandom);
    db = 16'($urandom);
    model(da, 6'b010110, 2'b10, wa, ea);
    model(db, 6'b000001, 2'b00, wb, eb);
    @(negedge clk);
    start      = 1'b1;
    data_in    = da;
    shift_code = 6'b010110;
    mode       = 2'b10;
    @(posedge clk);
    #1;
    data_in    = db;
    shift_code = 6'b000001;
    mode       = 2'b00;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (k == 3) begin
        checks++;
        if (done !== 1'b1 || data_out !== wa) begin
          errors++;
          $display("FAIL held_first got d%0b %h want 1 %h",
                   done, data_out, wa);
        end
      end
      if (k == 4) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle_accept got b%0b d%0b want 1 0",
                   busy, done);
        end
      end
      if (k == 5) start = 1'b0;
      if (k == 7) begin
        checks++;
        if (done !== 1'b1 || data_out !== wb) begin
          errors++;
          $display("FAIL held_second got d%0b %h want 1 %h",
                   done, data_out, wb);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL held_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start      = 1'b1;
    data_in    = 16'hFFFF;
    shift_code = 6'b000001;
    mode       = 2'b10;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || data_out !== 16'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got b%0b out=%h d%0b want 0 0 0",
               busy, data_out, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL in_reset got d%0b b%0b want 0 0", done, busy);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    start      = 1'b1;
    data_in    = 16'h7FFF;
    shift_code = 6'b000001;
    mode       = 2'b01;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_accept got b%0b want 1", busy);
    end
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 3 || data_out !== 16'h3FFF || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sra got %h l%0d e%0b want 3fff l3 e0",
               data_out, lat, err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_hold();
    test_random();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
